nibble_sort_ctrl: RTL and testbench

Sequencing controller that sorts N packed W-bit values into ascending order with a single shared magnitude comparator (a > b / a = b / a < b) and a bubble-sort schedule. The block captures a vector on `start`, runs one adjacent-pair compare per clock, and swaps on a strict greater-than result. It exits early after a pass with no swaps and reports the result with a one-cycle `done` pulse. It sits between a loader (testbench or upstream register file) and any consumer of ordered nibbles.

---
 rtl/nibble_sort_ctrl.sv | 149 ++++++++++++++
 tb/tb_nibble_sort_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/nibble_sort_ctrl.sv
// Bubble-sort sequencer for N packed W-bit entries. One shared magnitude
// comparator looks at pair (j, j+1) each cycle, and the sort stops early after a pass with no swaps.

module nibble_mag_cmp #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         a_g_b,
    output logic         a_e_b,
    output logic         b_g_a
);
    assign a_g_b = (a > b);
    assign a_e_b = (a == b);
    assign b_g_a = (a < b);
endmodule

module nibble_sort_ctrl #(
    parameter int N = 4,
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N*W-1:0] din,
    output logic           busy,
    output logic           done,
    output logic [N*W-1:0] dout,
    output logic [7:0]     swap_cnt
);
    typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

    localparam logic [3:0] LAST = 4'(N - 2);

    state_t               state_q, state_d;
    logic [N-1:0][W-1:0]  e_q, e_d;
    logic [3:0]           j_q, j_d;
    logic [3:0]           pass_q, pass_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 swp_q, swp_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [W-1:0]         cmp_a, cmp_b;
    logic                 a_g_b, a_e_b, b_g_a;
    logic                 swap_now;

    // The pair-select mux is the only thing that feeds the comparator.
    always_comb begin
        cmp_a = '0;
        cmp_b = '0;
        for (int k = 0; k < N - 1; k++) begin
            if (j_q == 4'(k)) begin
                cmp_a = e_q[k];
                cmp_b = e_q[k+1];
            end
        end
    end

    nibble_mag_cmp #(.W(W)) u_cmp (
        .a     (cmp_a),
        .b     (cmp_b),
        .a_g_b (a_g_b),
        .a_e_b (a_e_b),
        .b_g_a (b_g_a)
    );

    // Only a strict greater-than swaps. Equal and less-than results both hold the pair.
    assign swap_now = a_g_b && !a_e_b && !b_g_a;

    always_comb begin
        state_d = state_q;
        e_d     = e_q;
        j_d     = j_q;
        pass_d  = pass_q;
        cnt_d   = cnt_q;
        swp_d   = swp_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    e_d     = din;
                    j_d     = '0;
                    pass_d  = '0;
                    cnt_d   = '0;
                    swp_d   = 1'b0;
                    state_d = SORT;
                end else begin
                    state_d = IDLE;
                end
            end
            SORT: begin
                if (swap_now) begin
                    for (int k = 0; k < N - 1; k++) begin
                        if (j_q == 4'(k)) begin
                            e_d[k]   = cmp_b;
                            e_d[k+1] = cmp_a;
                        end
                    end
                    cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                    swp_d = 1'b1;
                end
                // The last compare of a pass counts toward the early-exit decision.
                if (j_q == LAST) begin
                    if (!(swp_q || swap_now) || pass_q == LAST) begin
                        state_d = DONE;
                    end else begin
                        pass_d = pass_q + 4'd1;
                        j_d    = '0;
                        swp_d  = 1'b0;
                    end
                end else begin
                    j_d = j_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == SORT);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            e_q     <= '0;
            j_q     <= '0;
            pass_q  <= '0;
            cnt_q   <= '0;
            swp_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            e_q     <= e_d;
            j_q     <= j_d;
            pass_q  <= pass_d;
            cnt_q   <= cnt_d;
            swp_q   <= swp_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign dout     = e_q;
    assign swap_cnt = cnt_q;
endmodule

// File: tb/tb_nibble_sort_ctrl.sv
// Directed bench for nibble_sort_ctrl. It runs a table of N=4 vectors, the reset, ignored-start and
// back-to-back sequences, and every N=2 operand pair.

module tb_nibble_sort_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        start4, start2;
    logic [15:0] din4, dout4;
    logic [7:0]  din2, dout2;
    logic        busy4, done4, busy2, done2;
    logic [7:0]  sw4, sw2;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    nibble_sort_ctrl #(.N(4), .W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .din(din4),
        .busy(busy4), .done(done4), .dout(dout4), .swap_cnt(sw4)
    );

    nibble_sort_ctrl #(.N(2), .W(4)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .din(din2),
        .busy(busy2), .done(done2), .dout(dout2), .swap_cnt(sw2)
    );

    typedef struct {
        logic [15:0] din;
        logic [15:0] exp_d;
        logic [7:0]  exp_s;
        int          exp_c;
    } vec_t;

    vec_t tbl[6];

    function automatic logic [15:0] pack4(input logic [3:0] e0, e1, e2, e3);
        return {e3, e2, e1, e0};
    endfunction

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Presents din and pulses start across one edge (E0). Returns #1 after E0.
    task automatic applyStimulus(input logic [15:0] d);
        @(negedge clk);
        din4   = d;
        start4 = 1'b1;
        @(posedge clk);
        #1 start4 = 1'b0;
    endtask

    // Waits for done, counting edges from E0. It can inject a start in mid-sort,
    // or chain the next start into the DONE cycle.
    task automatic waitDone(input string nm, input logic [15:0] exp_d, input logic [7:0] exp_s,
                            input int exp_c, input bit poke, input bit chain,
                            input logic [15:0] chain_din);
        int lat;
        int busy_hi;
        lat     = -1;
        busy_hi = busy4 ? 1 : 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done4) begin
                lat = k;
                if (chain) begin
                    din4   = chain_din;
                    start4 = 1'b1;
                end
                break;
            end
            if (busy4) busy_hi++;
            if (poke && k == 2) begin
                din4   = pack4(4'hF, 4'hE, 4'hD, 4'hC);
                start4 = 1'b1;
            end else if (poke && k == 3) begin
                start4 = 1'b0;
            end
        end
        if (lat < 0) begin
            n_vec++;
            n_miss++;
            $display("[TB] FAIL %s_timeout: no done within 40 cycles, expected at %0d", nm, exp_c);
        end
        checkOutput({nm, "_latency"}, 32'(lat), 32'(exp_c));
        checkOutput({nm, "_busy_cycles"}, 32'(busy_hi), 32'(exp_c));
        checkOutput({nm, "_busy_at_done"}, {31'd0, busy4}, 32'd0);
        checkOutput({nm, "_dout"}, {16'd0, dout4}, {16'd0, exp_d});
        checkOutput({nm, "_swaps"}, {24'd0, sw4}, {24'd0, exp_s});
        if (!chain) begin
            @(posedge clk);
            #1;
            checkOutput({nm, "_done_pulse"}, {31'd0, done4}, 32'd0);
            checkOutput({nm, "_dout_hold"}, {16'd0, dout4}, {16'd0, exp_d});
        end
    endtask

    initial begin
        tbl[0] = '{pack4(3, 2, 1, 0),  pack4(0, 1, 2, 3),  8'd6, 9};
        tbl[1] = '{pack4(1, 4, 9, 15), pack4(1, 4, 9, 15), 8'd0, 3};
        tbl[2] = '{pack4(5, 5, 5, 5),  pack4(5, 5, 5, 5),  8'd0, 3};
        tbl[3] = '{pack4(15, 0, 7, 7), pack4(0, 7, 7, 15), 8'd3, 6};
        tbl[4] = '{pack4(0, 0, 15, 1), pack4(0, 0, 1, 15), 8'd1, 6};
        tbl[5] = '{pack4(9, 3, 3, 1),  pack4(1, 3, 3, 9),  8'd5, 9};

        rst    = 1'b1;
        start4 = 1'b0;
        start2 = 1'b0;
        din4   = '0;
        din2   = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", {31'd0, busy4}, 32'd0);
        checkOutput("reset_done", {31'd0, done4}, 32'd0);
        checkOutput("reset_dout", {16'd0, dout4}, 32'd0);
        checkOutput("reset_swaps", {24'd0, sw4}, 32'd0);
        rst = 1'b0;

        // Reset mid-sort: after three compares the reversed vector has already swapped.
        applyStimulus(pack4(3, 2, 1, 0));
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst_busy", {31'd0, busy4}, 32'd0);
        checkOutput("midrst_done", {31'd0, done4}, 32'd0);
        checkOutput("midrst_dout", {16'd0, dout4}, 32'd0);
        checkOutput("midrst_swaps", {24'd0, sw4}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            applyStimulus(tbl[i].din);
            waitDone($sformatf("vec%0d", i), tbl[i].exp_d, tbl[i].exp_s, tbl[i].exp_c, 1'b0, 1'b0, '0);
        end

        // A start with new data during SORT must not disturb the sort in progress.
        applyStimulus(pack4(3, 2, 1, 0));
        waitDone("ignored_start", pack4(0, 1, 2, 3), 8'd6, 9, 1'b1, 1'b0, '0);

        // A start held through the DONE cycle begins the next sort with no gap.
        applyStimulus(pack4(3, 2, 1, 0));
        waitDone("b2b_first", pack4(0, 1, 2, 3), 8'd6, 9, 1'b0, 1'b1, pack4(2, 1, 0, 3));
        @(posedge clk);
        #1 start4 = 1'b0;
        checkOutput("b2b_done_low", {31'd0, done4}, 32'd0);
        checkOutput("b2b_busy_high", {31'd0, busy4}, 32'd1);
        waitDone("b2b_second", pack4(0, 1, 2, 3), 8'd3, 9, 1'b0, 1'b0, '0);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                logic [3:0] av, bv, mn, mx;
                int lat;
                av = 4'(a);
                bv = 4'(b);
                mn = (av < bv) ? av : bv;
                mx = (av < bv) ? bv : av;
                @(negedge clk);
                din2   = {bv, av};
                start2 = 1'b1;
                @(posedge clk);
                #1 start2 = 1'b0;
                lat = -1;
                for (int k = 1; k <= 10; k++) begin
                    @(posedge clk);
                    #1;
                    if (done2) begin
                        lat = k;
                        break;
                    end
                end
                checkOutput($sformatf("pair_%0d_%0d_latency", a, b), 32'(lat), 32'd1);
                checkOutput($sformatf("pair_%0d_%0d_dout", a, b), {24'd0, dout2}, {24'd0, mx, mn});
                checkOutput($sformatf("pair_%0d_%0d_swaps", a, b), {24'd0, sw2},
                            (a > b) ? 32'd1 : 32'd0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
